// File: rtl/snake_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : snake_move_scheduler
//  Description : Control core of the snake game. Decodes PS/2 scan-code bytes
//                into game commands, runs the game state machine, generates
//                the movement tick and queues up to CMD_DEPTH pending turns.
//                One step pulse plus direction is issued per movement tick.
//  Ports       : CLK        - system clock
//                RST_N      - asynchronous active-low reset
//                KeyIn      - scan-code byte, qualified by key_valid
//                key_valid  - one-cycle strobe per received byte
//                collide    - head outside playfield (level)
//                step       - one-cycle pulse: advance one segment in dir
//                dir        - 00 right, 01 left, 10 up, 11 down
//                load_start - one-cycle pulse: load start position
//                blank      - screen blacked out
//                game_state - 0 IDLE, 1 RUN, 2 PAUSE, 3 OVER, 4 BLANK
//                fast       - fast tick period selected
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_move_scheduler #(
    parameter int TICK_SLOW = 10000000,
    parameter int TICK_FAST = 2000000,
    parameter int CNT_W     = 24,
    parameter int CMD_DEPTH = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] KeyIn,
    input  logic       key_valid,
    input  logic       collide,
    output logic       step,
    output logic [1:0] dir,
    output logic       load_start,
    output logic       blank,
    output logic [2:0] game_state,
    output logic       fast
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RUN   = 3'd1;
    localparam logic [2:0] c_PAUSE = 3'd2;
    localparam logic [2:0] c_OVER  = 3'd3;
    localparam logic [2:0] c_BLANK = 3'd4;

    localparam int              c_QW      = $clog2(CMD_DEPTH + 1);
    localparam logic [c_QW-1:0] c_QFULL   = c_QW'(CMD_DEPTH);
    localparam logic [CNT_W-1:0] c_SLOW_M1 = CNT_W'(TICK_SLOW - 1);
    localparam logic [CNT_W-1:0] c_FAST_M1 = CNT_W'(TICK_FAST - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_brk;
    logic             r_step;
    logic [1:0]       r_dir;
    logic             r_load;
    logic             r_blank;
    logic             r_fast;
    logic [1:0]       r_q [CMD_DEPTH];
    logic [c_QW-1:0]  r_qCount;

    logic             w_start, w_pause, w_resume, w_esc, w_fastKey, w_normKey;
    logic             w_dirKey;
    logic [1:0]       w_keyDir;
    logic [1:0]       w_ref;
    logic             w_run, w_tick, w_collideHit, w_stepGo, w_pop, w_push;
    logic [CNT_W-1:0] w_periodM1;
    logic [c_QW-1:0]  w_wrIdx;

    // Byte decode. The byte following F0 (break prefix) is swallowed here
    // because r_brk is still set; F0 and E0 themselves decode to nothing.
    always_comb begin
        w_start   = 1'b0;
        w_pause   = 1'b0;
        w_resume  = 1'b0;
        w_esc     = 1'b0;
        w_fastKey = 1'b0;
        w_normKey = 1'b0;
        w_dirKey  = 1'b0;
        w_keyDir  = 2'b00;
        if (key_valid && !r_brk) begin
            case (KeyIn)
                8'h1B: w_start   = 1'b1;
                8'h4D: w_pause   = 1'b1;
                8'h2D: w_resume  = 1'b1;
                8'h76: w_esc     = 1'b1;
                8'h79: w_fastKey = 1'b1;
                8'h7B: w_normKey = 1'b1;
                8'h74: begin w_dirKey = 1'b1; w_keyDir = 2'b00; end
                8'h6B: begin w_dirKey = 1'b1; w_keyDir = 2'b01; end
                8'h75: begin w_dirKey = 1'b1; w_keyDir = 2'b10; end
                8'h72: begin w_dirKey = 1'b1; w_keyDir = 2'b11; end
                default: ;
            endcase
        end
    end

    // Reference for turn filtering: the last queued turn, or the current
    // direction when nothing is pending.
    always_comb begin
        w_ref = r_dir;
        for (int i = 0; i < CMD_DEPTH; i++) begin
            if (r_qCount == c_QW'(i + 1)) w_ref = r_q[i];
        end
    end

    assign w_run        = (r_state == c_RUN);
    assign w_periodM1   = r_fast ? c_FAST_M1 : c_SLOW_M1;
    // ">=" so a switch to fast with the count already beyond the fast limit
    // fires on the very next cycle instead of wrapping the counter.
    assign w_tick       = w_run && (r_cnt >= w_periodM1);
    assign w_collideHit = w_run && collide;
    // Start, ESC and a collision all override the tick; pause does not.
    assign w_stepGo     = w_tick && !w_start && !w_esc && !w_collideHit;
    assign w_pop        = w_stepGo && (r_qCount != '0);
    // Reverse direction differs only in the LSB (right/left, up/down).
    assign w_push       = w_dirKey && (r_state == c_RUN || r_state == c_PAUSE)
                          && (w_keyDir != w_ref)
                          && (w_keyDir != {w_ref[1], ~w_ref[0]})
                          && ((r_qCount != c_QFULL) || w_pop);
    assign w_wrIdx      = r_qCount - c_QW'(w_pop);

    // Break-prefix flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_brk <= 1'b0;
        end else if (key_valid) begin
            if (r_brk)               r_brk <= 1'b0;
            else if (KeyIn == 8'hF0) r_brk <= 1'b1;
        end
    end

    // Game state machine, tick counter and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
            r_dir   <= 2'b00;
            r_load  <= 1'b0;
            r_blank <= 1'b0;
            r_fast  <= 1'b0;
        end else begin
            r_step <= w_stepGo;
            r_load <= w_start;

            if (w_start)                               r_state <= c_RUN;
            else if (w_esc)                            r_state <= c_BLANK;
            else if (w_collideHit)                     r_state <= c_OVER;
            else if (w_pause && r_state == c_RUN)      r_state <= c_PAUSE;
            else if (w_resume && r_state == c_PAUSE)   r_state <= c_RUN;

            if (w_start)                  r_cnt <= '0;
            else if (w_run)               r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            else if (r_state != c_PAUSE)  r_cnt <= '0;

            if (w_start)    r_dir <= 2'b00;
            else if (w_pop) r_dir <= r_q[0];

            if (w_start)    r_blank <= 1'b0;
            else if (w_esc) r_blank <= 1'b1;

            if (r_state != c_BLANK) begin
                if (w_fastKey)      r_fast <= 1'b1;
                else if (w_normKey) r_fast <= 1'b0;
            end
        end
    end

    // Turn queue: entry 0 is the head. A pop shifts everything down; a
    // simultaneous push lands in the slot just past the surviving entries.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_qCount <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) r_q[i] <= 2'b00;
        end else if (w_start) begin
            r_qCount <= '0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < CMD_DEPTH - 1; i++) r_q[i] <= r_q[i + 1];
            end
            if (w_push) begin
                for (int i = 0; i < CMD_DEPTH; i++) begin
                    if (w_wrIdx == c_QW'(i)) r_q[i] <= w_keyDir;
                end
            end
            r_qCount <= r_qCount + c_QW'(w_push) - c_QW'(w_pop);
        end
    end

    assign step       = r_step;
    assign dir        = r_dir;
    assign load_start = r_load;
    assign blank      = r_blank;
    assign game_state = r_state;
    assign fast       = r_fast;

endmodule
`default_nettype wire

// File: tb/tb_snake_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_move_scheduler
//  Description : Self-checking bench for snake_move_scheduler with short tick
//                periods (8 slow / 4 fast). A behavioural game model is
//                compared against the outputs every cycle; directed scenarios
//                add literal expectations, then random key traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_move_scheduler;

    localparam int TS = 8;
    localparam int TF = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] KeyIn = 8'h00;
    logic       key_valid = 1'b0;
    logic       collide = 1'b0;
    logic       step;
    logic [1:0] dir;
    logic       load_start;
    logic       blank;
    logic [2:0] game_state;
    logic       fast;

    snake_move_scheduler #(
        .TICK_SLOW(TS),
        .TICK_FAST(TF),
        .CNT_W    (4),
        .CMD_DEPTH(2)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .KeyIn     (KeyIn),
        .key_valid (key_valid),
        .collide   (collide),
        .step      (step),
        .dir       (dir),
        .load_start(load_start),
        .blank     (blank),
        .game_state(game_state),
        .fast      (fast)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // ---------------- behavioural model ----------------
    // Game states: 0 idle, 1 run, 2 pause, 3 over, 4 blank
    logic [2:0] m_state;
    int         m_cnt;      // cycles spent running since the last move
    bit         m_fast, m_blank, m_step, m_load, m_brk;
    bit   [1:0] m_dir;
    bit   [1:0] mq[$];      // pending turns, front = next to apply

    function automatic bit [1:0] opposite(input bit [1:0] d);
        case (d)
            2'd0: return 2'd1;
            2'd1: return 2'd0;
            2'd2: return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    always @(posedge CLK or negedge RST_N) begin : model
        bit st, pz, rs, esc, fk, nk, dk, run, tick, hit, go, ok;
        bit [1:0] kd, rf;
        logic [2:0] old;
        if (!RST_N) begin
            m_state = 3'd0; m_cnt = 0; m_fast = 0; m_blank = 0;
            m_step = 0; m_load = 0; m_brk = 0; m_dir = 2'd0;
            mq.delete();
        end else begin
            st = 0; pz = 0; rs = 0; esc = 0; fk = 0; nk = 0; dk = 0; kd = 0; ok = 0;
            if (key_valid) begin
                if (m_brk) m_brk = 0;
                else if (KeyIn == 8'hF0) m_brk = 1;
                else begin
                    case (KeyIn)
                        8'h1B: st = 1;
                        8'h4D: pz = 1;
                        8'h2D: rs = 1;
                        8'h76: esc = 1;
                        8'h79: fk = 1;
                        8'h7B: nk = 1;
                        8'h74: begin dk = 1; kd = 2'd0; end
                        8'h6B: begin dk = 1; kd = 2'd1; end
                        8'h75: begin dk = 1; kd = 2'd2; end
                        8'h72: begin dk = 1; kd = 2'd3; end
                        default: ;
                    endcase
                end
            end
            old  = m_state;
            run  = (old == 3'd1);
            tick = run && (m_cnt + 1 >= (m_fast ? TF : TS));
            hit  = run && collide;
            go   = tick && !st && !esc && !hit;
            if (dk && (old == 3'd1 || old == 3'd2)) begin
                rf = (mq.size() > 0) ? mq[mq.size() - 1] : m_dir;
                ok = (kd != rf) && (kd != opposite(rf)) &&
                     (mq.size() < 2 || (go && mq.size() > 0));
            end
            if (go && mq.size() > 0) m_dir = mq.pop_front();
            if (ok) mq.push_back(kd);
            m_step = go;
            m_load = st;
            if (st)              m_cnt = 0;
            else if (run)        m_cnt = tick ? 0 : m_cnt + 1;
            else if (old != 3'd2) m_cnt = 0;
            if (old != 3'd4) begin
                if (fk) m_fast = 1;
                else if (nk) m_fast = 0;
            end
            if (st) m_blank = 0;
            else if (esc) m_blank = 1;
            if (st)                        m_state = 3'd1;
            else if (esc)                  m_state = 3'd4;
            else if (hit)                  m_state = 3'd3;
            else if (pz && old == 3'd1)    m_state = 3'd2;
            else if (rs && old == 3'd2)    m_state = 3'd1;
            if (st) begin
                mq.delete();
                m_dir = 2'd0;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge CLK) begin
        if (chk_on && RST_N) begin
            n_vec++;
            if ({step, dir, load_start, blank, game_state, fast} !==
                {m_step, m_dir, m_load, m_blank, m_state, m_fast}) begin
                n_err++;
                $display("FAIL model t=%0t: dut step=%b dir=%b load=%b blank=%b st=%0d fast=%b, model step=%b dir=%b load=%b blank=%b st=%0d fast=%b",
                         $time, step, dir, load_start, blank, game_state, fast,
                         m_step, m_dir, m_load, m_blank, m_state, m_fast);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one byte for one cycle; called at a falling edge, returns at the next.
    task automatic send(input logic [7:0] b);
        KeyIn = b;
        key_valid = 1'b1;
        @(negedge CLK);
        key_valid = 1'b0;
    endtask

    // Falling edges until step is seen; -1 if the bound expires.
    task automatic wait_step(output int n);
        n = 0;
        while (n < 60) begin
            @(negedge CLK);
            n++;
            if (step === 1'b1) break;
        end
        if (step !== 1'b1) n = -1;
    endtask

    task automatic do_reset_pulse();
        key_valid = 1'b0;
        collide   = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("rst_state", game_state, 0);
        chk("rst_outs", {step, dir, load_start, blank, fast}, 0);
        #1 RST_N = 1'b1;
    endtask

    logic [7:0] keys [14];

    initial begin : stim
        int n;
        keys = '{8'h1B, 8'h1B, 8'h4D, 8'h2D, 8'h76, 8'h74, 8'h6B, 8'h75,
                 8'h72, 8'h79, 8'h7B, 8'hF0, 8'hE0, 8'h00};
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        chk_on = 1'b1;

        // reset state
        chk("reset_state", game_state, 0);
        chk("reset_outs", {step, dir, load_start, blank, fast}, 0);

        // start: load pulse, run, steps every 8 cycles heading right
        send(8'h1B);
        chk("start_load", load_start, 1);
        chk("start_state", game_state, 1);
        wait_step(n);
        chk("first_step_latency", n, 8);
        chk("first_step_dir", dir, 0);
        wait_step(n);
        chk("step_period_slow", n, 8);

        // two queued turns: up then left
        send(8'h75);
        send(8'h6B);
        wait_step(n);
        chk("turn1_dir", dir, 2);
        wait_step(n);
        chk("turn2_dir", dir, 1);

        // back to right, then reverse and break-code presses are dropped
        send(8'h75);
        wait_step(n);
        send(8'h74);
        wait_step(n);
        chk("back_right", dir, 0);
        send(8'h6B);
        wait_step(n);
        chk("reverse_dropped", dir, 0);
        send(8'hF0);
        send(8'h75);
        wait_step(n);
        chk("break_dropped", dir, 0);

        // pause straight after a move: count frozen at 1
        send(8'h4D);
        chk("pause_state", game_state, 2);
        begin : pause_hold
            int seen;
            seen = 0;
            repeat (50) begin
                @(negedge CLK);
                if (step) seen++;
            end
            chk("pause_no_step", seen, 0);
        end
        send(8'h2D);
        chk("resume_state", game_state, 1);
        wait_step(n);
        chk("resume_remaining", n, 7);

        // collision, blanking, restart
        collide = 1'b1;
        @(negedge CLK);
        chk("over_state", game_state, 3);
        begin : over_hold
            int seen;
            seen = 0;
            repeat (12) begin
                @(negedge CLK);
                if (step) seen++;
            end
            chk("over_no_step", seen, 0);
        end
        collide = 1'b0;
        send(8'h76);
        chk("esc_state", game_state, 4);
        chk("esc_blank", blank, 1);
        send(8'h1B);
        chk("restart_state", game_state, 1);
        chk("restart_blank", blank, 0);

        // fast mode switched on at count 6
        repeat (6) @(negedge CLK);
        send(8'h79);
        wait_step(n);
        chk("fast_immediate", n, 1);
        wait_step(n);
        chk("fast_period", n, 4);
        wait_step(n);
        chk("fast_period2", n, 4);
        chk("fast_flag", fast, 1);
        send(8'h7B);
        wait_step(n);
        chk("normal_remaining", n, 7);
        wait_step(n);
        chk("normal_period", n, 8);
        chk("normal_flag", fast, 0);

        // asynchronous reset mid-run
        repeat (3) @(negedge CLK);
        do_reset_pulse();

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            if ($urandom_range(0, 699) == 0) begin
                do_reset_pulse();
            end else begin
                collide   = ($urandom_range(0, 49) == 0);
                key_valid = ($urandom_range(0, 3) == 0);
                KeyIn     = keys[$urandom_range(0, 13)];
                if (KeyIn == 8'h00) KeyIn = 8'($urandom);
            end
        end
        @(negedge CLK);
        key_valid = 1'b0;
        collide   = 1'b0;
        @(negedge CLK);
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
